// File: rtl/sparse_chunk_encoder.sv
// Dense-to-sparse chunk encoder: captures one MEM_SIZE-byte chunk, then drains map plus packed
// non-zero bytes in the cluster write format. Define SPARSE_ENC_STATS_EN to add nz_count_o.
module sparse_chunk_encoder #(
  parameter int unsigned MEM_SIZE = 128,
  parameter int unsigned BUS_SIZE = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [BUS_SIZE*8-1:0]                   dense_data_i,
  input  logic                                    dense_valid_i,
  output logic                                    dense_ready_o,
  output logic                                    full_o,
  input  logic                                    drain_req_i,
  output logic [BUS_SIZE-1:0]                     sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                   nonzero_data_o,
  output logic                                    wr_valid_o,
  output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]    wr_count_o,
`ifdef SPARSE_ENC_STATS_EN
  output logic [$clog2(MEM_SIZE):0]               nz_count_o,
`endif
  output logic                                    drain_done_o
);

  localparam int unsigned BEAT_NUM = MEM_SIZE / BUS_SIZE;
  localparam int unsigned AW       = $clog2(MEM_SIZE);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned CW       = $clog2(BEAT_NUM);
  localparam int unsigned OW       = $clog2(BUS_SIZE) + 1;

  typedef enum logic [1:0] {StFill, StFull, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       in_cnt_q, in_cnt_d;
  logic [CW-1:0]       drn_cnt_q, drn_cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [BUS_SIZE-1:0] map_q [BEAT_NUM];
  logic [BUS_SIZE-1:0] map_d [BEAT_NUM];
  logic [7:0]          data_q [MEM_SIZE];
  logic [7:0]          data_d [MEM_SIZE];

  logic [BUS_SIZE-1:0] beat_map;
  logic [OW-1:0]       offset;
  logic [AW-1:0]       widx;
  logic [AW-1:0]       slot;
  logic                last_drain;

  assign last_drain = (drn_cnt_q == CW'(BEAT_NUM - 1));

  always_comb begin
    beat_map = '0;
    for (int b = 0; b < BUS_SIZE; b++) begin
      beat_map[b] = |dense_data_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    drn_cnt_d = drn_cnt_q;
    ptr_d     = ptr_q;
    map_d     = map_q;
    data_d    = data_q;
    offset    = '0;
    widx      = '0;
    unique case (state_q)
      StFill: begin
        if (dense_valid_i) begin
          // Non-zero bytes land in consecutive slots, ordered by ascending byte lane.
          for (int b = 0; b < BUS_SIZE; b++) begin
            if (beat_map[b]) begin
              widx         = AW'(ptr_q + PW'(offset));
              data_d[widx] = dense_data_i[8*b +: 8];
              offset       = offset + OW'(1);
            end
          end
          map_d[in_cnt_q] = beat_map;
          ptr_d           = ptr_q + PW'(offset);
          if (in_cnt_q == CW'(BEAT_NUM - 1)) begin
            in_cnt_d = '0;
            state_d  = StFull;
          end else begin
            in_cnt_d = in_cnt_q + CW'(1);
          end
        end
      end
      StFull: begin
        if (drain_req_i) state_d = StDrain;
      end
      StDrain: begin
        if (last_drain) begin
          // Clear on the last beat so the next chunk starts from an empty buffer.
          for (int i = 0; i < BEAT_NUM; i++) map_d[i] = '0;
          for (int i = 0; i < MEM_SIZE; i++) data_d[i] = '0;
          ptr_d     = '0;
          drn_cnt_d = '0;
          state_d   = StFill;
        end else begin
          drn_cnt_d = drn_cnt_q + CW'(1);
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFill;
      in_cnt_q  <= '0;
      drn_cnt_q <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < BEAT_NUM; i++) map_q[i] <= '0;
      for (int i = 0; i < MEM_SIZE; i++) data_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      ptr_q     <= ptr_d;
      map_q     <= map_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    dense_ready_o  = (state_q == StFill);
    full_o         = (state_q == StFull);
    wr_valid_o     = 1'b0;
    wr_count_o     = '0;
    sparsemap_o    = '0;
    nonzero_data_o = '0;
    drain_done_o   = 1'b0;
    slot           = '0;
    if (state_q == StDrain) begin
      wr_valid_o   = 1'b1;
      wr_count_o   = drn_cnt_q;
      sparsemap_o  = map_q[drn_cnt_q];
      drain_done_o = last_drain;
      for (int b = 0; b < BUS_SIZE; b++) begin
        slot = AW'(drn_cnt_q * BUS_SIZE + b);
        // Slots past the packed data are padding and always read as zero.
        if (PW'(slot) < ptr_q) nonzero_data_o[8*b +: 8] = data_q[slot];
      end
    end
  end

`ifdef SPARSE_ENC_STATS_EN
  assign nz_count_o = (state_q == StFill) ? '0 : ptr_q;
`endif

endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Scoreboard bench for sparse_chunk_encoder: expected drain beats are queued when a drain is
// requested and compared as the encoder emits them.
module tb_sparse_chunk_encoder;

  localparam int MEM   = 128;
  localparam int BUS   = 8;
  localparam int BEATS = MEM / BUS;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [BUS*8-1:0] dense_data_i;
  logic            dense_valid_i;
  logic            dense_ready_o;
  logic            full_o;
  logic            drain_req_i;
  logic [BUS-1:0]  sparsemap_o;
  logic [BUS*8-1:0] nonzero_data_o;
  logic            wr_valid_o;
  logic [3:0]      wr_count_o;
  logic            drain_done_o;
`ifdef SPARSE_ENC_STATS_EN
  logic [7:0]      nz_count_o;
`endif

  always #5 clk = ~clk;

  sparse_chunk_encoder #(
    .MEM_SIZE(MEM),
    .BUS_SIZE(BUS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .dense_data_i  (dense_data_i),
    .dense_valid_i (dense_valid_i),
    .dense_ready_o (dense_ready_o),
    .full_o        (full_o),
    .drain_req_i   (drain_req_i),
    .sparsemap_o   (sparsemap_o),
    .nonzero_data_o(nonzero_data_o),
    .wr_valid_o    (wr_valid_o),
    .wr_count_o    (wr_count_o),
`ifdef SPARSE_ENC_STATS_EN
    .nz_count_o    (nz_count_o),
`endif
    .drain_done_o  (drain_done_o)
  );

  typedef struct packed {
    logic [7:0]  map;
    logic [63:0] data;
    logic [3:0]  cnt;
    logic        done;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [7:0] chunk [MEM];
  int         exp_nz;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_valid_o) begin
        if (q.size() == 0) begin
          check_eq("spurious_wr", 64'(wr_valid_o), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check_eq("map", 64'(sparsemap_o), 64'(mon_e.map));
          check_eq("data", nonzero_data_o, mon_e.data);
          check_eq("wr_count", 64'(wr_count_o), 64'(mon_e.cnt));
          check_eq("drain_done", 64'(drain_done_o), 64'(mon_e.done));
        end
      end else begin
        check_eq("idle_ctl", {51'd0, drain_done_o, wr_count_o, sparsemap_o}, 64'd0);
        check_eq("idle_data", nonzero_data_o, 64'd0);
      end
    end
  end

  // Reference model: compact non-zero bytes, then slice map and data per beat.
  task automatic push_expected();
    logic [7:0] pk [MEM];
    int nz = 0;
    exp_t e;
    for (int i = 0; i < MEM; i++) pk[i] = 8'h00;
    for (int i = 0; i < MEM; i++) begin
      if (chunk[i] != 8'h00) begin
        pk[nz] = chunk[i];
        nz++;
      end
    end
    exp_nz = nz;
    for (int k = 0; k < BEATS; k++) begin
      e = '0;
      for (int b = 0; b < BUS; b++) begin
        e.map[b] = (chunk[k*BUS+b] != 8'h00);
        e.data[8*b +: 8] = pk[k*BUS+b];
      end
      e.cnt  = 4'(k);
      e.done = (k == BEATS - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_chunk(input int pulse_beat, input bit gaps);
    check_eq("ready_fill", 64'(dense_ready_o), 64'd1);
    for (int n = 0; n < BEATS; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        dense_valid_i = 1'b0;
        dense_data_i  = {$urandom, $urandom};
        @(negedge clk);
      end
      dense_valid_i = 1'b1;
      drain_req_i   = (n == pulse_beat);
      for (int b = 0; b < BUS; b++) dense_data_i[8*b +: 8] = chunk[n*BUS+b];
      @(negedge clk);
    end
    dense_valid_i = 1'b0;
    drain_req_i   = 1'b0;
    check_eq("full_after_fill", 64'(full_o), 64'd1);
    check_eq("ready_when_full", 64'(dense_ready_o), 64'd0);
  endtask

  task automatic start_drain();
    // Upstream pushes garbage while not ready; it must not be captured.
    dense_valid_i = 1'b1;
    dense_data_i  = {$urandom, $urandom};
    @(negedge clk);
    dense_valid_i = 1'b0;
    check_eq("full_hold", 64'(full_o), 64'd1);
    push_expected();
`ifdef SPARSE_ENC_STATS_EN
    check_eq("nz_count_full", 64'(nz_count_o), 64'(exp_nz));
`endif
    drain_req_i = 1'b1;
    @(negedge clk);
    drain_req_i = 1'b0;
  endtask

  task automatic do_drain();
    bit done = 1'b0;
    start_drain();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check_eq("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
    check_eq("full_after_drain", 64'(full_o), 64'd0);
    check_eq("ready_after_drain", 64'(dense_ready_o), 64'd1);
`ifdef SPARSE_ENC_STATS_EN
    check_eq("nz_count_fill", 64'(nz_count_o), 64'd0);
`endif
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < MEM; i++) chunk[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_i         = 1'b1;
    dense_valid_i = 1'b0;
    dense_data_i  = '0;
    drain_req_i   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(dense_ready_o), 64'd1);
    check_eq("rst_full", 64'(full_o), 64'd0);
    check_eq("rst_ctl", {51'd0, drain_done_o, wr_count_o, sparsemap_o}, 64'd0);
    check_eq("rst_valid", 64'(wr_valid_o), 64'd0);
    check_eq("rst_data", nonzero_data_o, 64'd0);
    rst_i  = 1'b0;
    mon_en = 1'b1;

    fill_const(8'h00);
    send_chunk(-1, 1'b0);
    do_drain();

    for (int i = 0; i < MEM; i++) chunk[i] = 8'(i + 1);
    send_chunk(-1, 1'b1);
    do_drain();

    fill_const(8'h00);
    chunk[1] = 8'd5;
    chunk[3] = 8'd7;
    chunk[6] = 8'd9;
    send_chunk(-1, 1'b0);
    do_drain();

    // drain_req during FILL must be dropped, not remembered.
    for (int i = 0; i < MEM; i++) chunk[i] = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
    send_chunk(4, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("full_wait_req", 64'(full_o), 64'd1);
    do_drain();

    // Reset while beat 6 is on the bus.
    fill_const(8'hff);
    send_chunk(-1, 1'b0);
    start_drain();
    repeat (6) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("rst_drain_valid", 64'(wr_valid_o), 64'd0);
    check_eq("rst_drain_full", 64'(full_o), 64'd0);
    check_eq("rst_drain_ready", 64'(dense_ready_o), 64'd1);
    q.delete();
    fill_const(8'h00);
    send_chunk(-1, 1'b0);
    do_drain();

    fill_const(8'hff);
    send_chunk(-1, 1'b1);
    do_drain();
    fill_const(8'h00);
    chunk[0] = 8'h11;
    send_chunk(-1, 1'b0);
    do_drain();

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MEM; i++) chunk[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      send_chunk(-1, 1'b1);
      do_drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
